// File: rtl/iob_timer_alarm_pkg.sv
// Shared constants, slot index width helper and slot record for the timer alarm scheduler.
package iob_timer_alarm_pkg;

    localparam int unsigned N_ALARMS_DEF = 4;
    localparam int unsigned TIME_W_DEF   = 64;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                  armed;
        logic                  pending;
        logic [TIME_W_DEF-1:0] deadline;
    } slot_t;

endpackage

// File: rtl/iob_timer_alarm_slot.sv
// One alarm slot: deadline, armed and pending state with arm/cancel/fire/ack priority.
module iob_timer_alarm_slot
    import iob_timer_alarm_pkg::*;
#(
    parameter int unsigned TIME_W = TIME_W_DEF
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              arm_i,
    input  logic [TIME_W-1:0] arm_deadline_i,
    input  logic              cancel_i,
    input  logic              hit_i,
    input  logic              ack_i,
    output logic              fire_o,
    output logic              armed_o,
    output logic              pending_o,
    output logic              pending_d_o,
    output logic [TIME_W-1:0] deadline_o
);

    logic              armed_q, armed_d;
    logic              pending_q, pending_d;
    logic [TIME_W-1:0] deadline_q, deadline_d;

    always_comb begin
        // A cancel landing on the scan hit suppresses the fire entirely.
        fire_o     = hit_i & armed_q & ~cancel_i;
        armed_d    = armed_q;
        pending_d  = pending_q;
        deadline_d = deadline_q;
        if (arm_i) begin
            armed_d    = 1'b1;
            deadline_d = arm_deadline_i;
        end else if (cancel_i || fire_o) begin
            armed_d = 1'b0;
        end
        if (fire_o) begin
            pending_d = 1'b1;
        end else if (ack_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            armed_q    <= 1'b0;
            pending_q  <= 1'b0;
            deadline_q <= '0;
        end else if (cke_i) begin
            armed_q    <= armed_d;
            pending_q  <= pending_d;
            deadline_q <= deadline_d;
        end
    end

    assign armed_o     = armed_q;
    assign pending_o   = pending_q;
    assign pending_d_o = pending_d;
    assign deadline_o  = deadline_q;

endmodule

// File: rtl/iob_timer_alarm_ctrl.sv
// Alarm scheduler sharing one timer among N_ALARMS requesters via a round-robin comparator scan.
module iob_timer_alarm_ctrl
    import iob_timer_alarm_pkg::*;
#(
    parameter  int unsigned N_ALARMS = N_ALARMS_DEF,
    parameter  int unsigned TIME_W   = TIME_W_DEF,
    localparam int unsigned ID_W     = id_width(N_ALARMS)
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_i,
    input  logic [TIME_W-1:0]   time_i,
    input  logic                sw_en_i,
    output logic                timer_en_o,
    input  logic                arm_valid_i,
    input  logic [ID_W-1:0]     arm_id_i,
    input  logic [TIME_W-1:0]   arm_deadline_i,
    output logic                arm_ready_o,
    input  logic                cancel_valid_i,
    input  logic [ID_W-1:0]     cancel_id_i,
    input  logic [N_ALARMS-1:0] ack_i,
    output logic [N_ALARMS-1:0] armed_o,
    output logic [N_ALARMS-1:0] pending_o,
    output logic [N_ALARMS-1:0] alarm_o,
    output logic                irq_o
);

    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [N_ALARMS-1:0] alarm_q;
    logic                irq_q;

    logic [N_ALARMS-1:0] armed, pending, pending_nxt, fire;
    logic [N_ALARMS-1:0] arm_sel, cancel_sel, hit_sel;
    logic [TIME_W-1:0]   deadline [N_ALARMS];
    logic                sel_armed, scan_hit;
    logic [TIME_W-1:0]   sel_deadline;

    always_comb begin
        arm_ready_o  = 1'b0;
        cancel_sel   = '0;
        sel_armed    = 1'b0;
        sel_deadline = '0;
        for (int unsigned k = 0; k < N_ALARMS; k++) begin
            if (arm_id_i == ID_W'(k)) arm_ready_o = ~armed[k];
            if (cancel_id_i == ID_W'(k)) cancel_sel[k] = cancel_valid_i;
            if (ptr_q == ID_W'(k)) begin
                sel_armed    = armed[k];
                sel_deadline = deadline[k];
            end
        end
    end

    // Single shared comparator on the slot under the scan pointer.
    assign scan_hit = sel_armed & (time_i >= sel_deadline);

    always_comb begin
        arm_sel = '0;
        hit_sel = '0;
        for (int unsigned k = 0; k < N_ALARMS; k++) begin
            arm_sel[k] = arm_valid_i & arm_ready_o & (arm_id_i == ID_W'(k));
            hit_sel[k] = scan_hit & (ptr_q == ID_W'(k));
        end
        ptr_d = (ptr_q == ID_W'(N_ALARMS - 1)) ? '0 : ptr_q + ID_W'(1);
    end

    for (genvar g = 0; g < N_ALARMS; g++) begin : g_slot
        iob_timer_alarm_slot #(
            .TIME_W(TIME_W)
        ) u_slot (
            .clk_i          (clk_i),
            .cke_i          (cke_i),
            .rst_i          (rst_i),
            .arm_i          (arm_sel[g]),
            .arm_deadline_i (arm_deadline_i),
            .cancel_i       (cancel_sel[g]),
            .hit_i          (hit_sel[g]),
            .ack_i          (ack_i[g]),
            .fire_o         (fire[g]),
            .armed_o        (armed[g]),
            .pending_o      (pending[g]),
            .pending_d_o    (pending_nxt[g]),
            .deadline_o     (deadline[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            alarm_q <= '0;
            irq_q   <= 1'b0;
        end else if (cke_i) begin
            ptr_q   <= ptr_d;
            alarm_q <= fire;
            irq_q   <= |pending_nxt;
        end else begin
            alarm_q <= '0;
        end
    end

    assign timer_en_o = sw_en_i | (|armed);
    assign armed_o    = armed;
    assign pending_o  = pending;
    assign alarm_o    = alarm_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_iob_timer_alarm_ctrl.sv
// Directed bench for iob_timer_alarm_ctrl with a per-cycle reference model of the slot rules.
module tb_iob_timer_alarm_ctrl;
    import iob_timer_alarm_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        cke, rst, sw_en, timer_en;
    logic [63:0] tm, arm_dl;
    logic        arm_valid, arm_ready, cancel_valid;
    logic [1:0]  arm_id, cancel_id;
    logic [3:0]  ack, armed_o, pending_o, alarm_o;
    logic        irq_o;

    always #5 clk = ~clk;

    iob_timer_alarm_ctrl #(
        .N_ALARMS(4),
        .TIME_W  (64)
    ) dut (
        .clk_i          (clk),
        .cke_i          (cke),
        .rst_i          (rst),
        .time_i         (tm),
        .sw_en_i        (sw_en),
        .timer_en_o     (timer_en),
        .arm_valid_i    (arm_valid),
        .arm_id_i       (arm_id),
        .arm_deadline_i (arm_dl),
        .arm_ready_o    (arm_ready),
        .cancel_valid_i (cancel_valid),
        .cancel_id_i    (cancel_id),
        .ack_i          (ack),
        .armed_o        (armed_o),
        .pending_o      (pending_o),
        .alarm_o        (alarm_o),
        .irq_o          (irq_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: scan slot = cycles since reset modulo N.
    slot_t      m_slot [N];
    int         m_scan;
    logic [3:0] m_alarm;
    logic       m_irq;
    bit         chk_en = 0;

    function automatic logic [3:0] m_armed_v();
        logic [3:0] r;
        for (int k = 0; k < N; k++) r[k] = m_slot[k].armed;
        return r;
    endfunction

    function automatic logic [3:0] m_pend_v();
        logic [3:0] r;
        for (int k = 0; k < N; k++) r[k] = m_slot[k].pending;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) m_slot[k] = '0;
            m_scan  = 0;
            m_alarm = '0;
            m_irq   = 1'b0;
        end else if (cke) begin
            bit fire, acc;
            int p;
            p    = m_scan;
            fire = m_slot[p].armed && (tm >= m_slot[p].deadline)
                   && !(cancel_valid && int'(cancel_id) == p);
            acc  = arm_valid && !m_slot[arm_id].armed;
            if (cancel_valid) m_slot[cancel_id].armed = 1'b0;
            if (fire) m_slot[p].armed = 1'b0;
            if (acc) begin
                m_slot[arm_id].armed    = 1'b1;
                m_slot[arm_id].deadline = arm_dl;
            end
            for (int k = 0; k < N; k++) if (ack[k]) m_slot[k].pending = 1'b0;
            if (fire) m_slot[p].pending = 1'b1;
            m_alarm = '0;
            if (fire) m_alarm[p] = 1'b1;
            m_irq  = |m_pend_v();
            m_scan = (m_scan + 1) % N;
        end else begin
            m_alarm = '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("armed_o", armed_o, m_armed_v());
            check("pending_o", pending_o, m_pend_v());
            check("alarm_o", alarm_o, m_alarm);
            check("irq_o", irq_o, m_irq);
            check("timer_en_o", timer_en, sw_en | (|m_armed_v()));
            check("arm_ready_o", arm_ready, !m_slot[arm_id].armed);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        arm_valid    = 1'b0;
        cancel_valid = 1'b0;
        ack          = '0;
    endtask

    task automatic arm(input int id, input logic [63:0] dl);
        arm_valid = 1'b1;
        arm_id    = 2'(id);
        arm_dl    = dl;
        step();
        idle();
    endtask

    task automatic wait_fire(input int slot, output bit found, output int lat);
        found = 0;
        lat   = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (alarm_o[slot]) begin
                found = 1;
                lat   = i;
                break;
            end
        end
    endtask

    task automatic wait_scan(input int target);
        for (int i = 0; i < N && m_scan != target; i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        int lat;
        logic [3:0] e;
        cke = 1'b1; rst = 1'b1; sw_en = 1'b0; tm = '0;
        arm_dl = '0; arm_id = '0; cancel_id = '0;
        idle();
        step();
        step();
        chk_en = 1;
        check("rst_armed", armed_o, 4'h0);
        check("rst_pending", pending_o, 4'h0);
        check("rst_alarm", alarm_o, 4'h0);
        check("rst_irq", irq_o, 1'b0);
        check("rst_timer_en", timer_en, 1'b0);
        rst = 1'b0;

        // 1: slot 2, deadline 100, armed at t=50
        tm = 50;
        arm(2, 100);
        check("t1_armed", armed_o, 4'b0100);
        check("t1_timer_en", timer_en, 1'b1);
        repeat (3) step();
        tm = 99;
        repeat (5) step();
        check("t1_no_early", pending_o, 4'h0);
        tm = 100;
        wait_fire(2, found, lat);
        check("t1_found", found, 1'b1);
        check("t1_latency_1_to_4", (lat >= 1 && lat <= 4), 1'b1);
        check("t1_pending", pending_o, 4'b0100);
        check("t1_irq", irq_o, 1'b1);
        check("t1_disarmed", armed_o, 4'h0);
        step();
        check("t1_single_pulse", alarm_o, 4'h0);

        // 2: past deadline fires on first visit, never in accept cycle
        ack = 4'b0100;
        step();
        idle();
        check("t2_acked", pending_o, 4'h0);
        check("t2_irq_low", irq_o, 1'b0);
        tm = 40;
        arm(0, 5);
        check("t2_no_alarm_accept", alarm_o, 4'h0);
        check("t2_armed", armed_o, 4'b0001);
        wait_fire(0, found, lat);
        check("t2_found", found, 1'b1);
        check("t2_latency_1_to_4", (lat >= 1 && lat <= 4), 1'b1);
        ack = '1;
        step();
        idle();

        // 3: cancel in the same cycle the scan hits slot 1
        tm = 300;
        arm(1, 200);
        wait_scan(1);
        cancel_valid = 1'b1;
        cancel_id    = 2'd1;
        step();
        idle();
        check("t3_no_alarm", alarm_o, 4'h0);
        check("t3_no_pending", pending_o, 4'h0);
        check("t3_disarmed", armed_o, 4'h0);

        // 4: arm of an armed slot is refused and deadline unchanged
        tm = 0;
        arm(3, 500);
        arm_valid = 1'b1;
        arm_id    = 2'd3;
        arm_dl    = 10;
        #1;
        check("t4_ready_low", arm_ready, 1'b0);
        step();
        idle();
        tm = 450;
        repeat (6) step();
        check("t4_still_armed", armed_o, 4'b1000);
        check("t4_no_pending", pending_o, 4'h0);
        tm = 500;
        wait_fire(3, found, lat);
        check("t4_found", found, 1'b1);

        // 5: four slots at deadline 10 fire in pointer order
        ack = '1;
        step();
        idle();
        tm = 0;
        for (int s = 0; s < N; s++) arm(s, 10);
        wait_scan(0);
        tm = 10;
        for (int i = 0; i < N; i++) begin
            step();
            e = 4'b0001 << i;
            check("t5_pulse_order", alarm_o, e);
        end
        check("t5_pending_all", pending_o, 4'hF);
        check("t5_irq", irq_o, 1'b1);
        ack = 4'h5;
        step();
        idle();
        check("t5_pending_after_ack", pending_o, 4'hA);
        check("t5_irq_held", irq_o, 1'b1);

        // 6: ack and re-fire of slot 0 in the same cycle
        arm(0, 10);
        wait_fire(0, found, lat);
        check("t6_first_fire", found, 1'b1);
        arm(0, 10);
        wait_scan(0);
        ack = 4'b0001;
        step();
        idle();
        check("t6_refire_alarm", alarm_o, 4'b0001);
        check("t6_pending_kept", pending_o, 4'b1011);

        // clock enable low freezes state and blocks pulses
        arm(2, 20);
        cke = 1'b0;
        tm  = 30;
        repeat (6) step();
        check("cke_frozen_armed", armed_o, 4'b0100);
        check("cke_no_alarm", alarm_o, 4'h0);
        cke = 1'b1;
        wait_fire(2, found, lat);
        check("cke_resume_fire", found, 1'b1);

        // reset mid-operation
        arm(1, 64'd9999);
        sw_en = 1'b1;
        rst   = 1'b1;
        step();
        check("rst2_armed", armed_o, 4'h0);
        check("rst2_pending", pending_o, 4'h0);
        check("rst2_alarm", alarm_o, 4'h0);
        check("rst2_irq", irq_o, 1'b0);
        check("rst2_timer_en_sw", timer_en, 1'b1);
        rst   = 1'b0;
        sw_en = 1'b0;
        step();
        check("rst2_timer_en_off", timer_en, 1'b0);

        @(negedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
